// File: rtl/peg_l2_fcs_chk_if.sv
// Receive stream into the FCS checker, plus the stripped payload and per-frame status coming out of it.
interface peg_l2_fcs_chk_if;
    logic        rx_valid;
    logic        rx_sof;
    logic        rx_eof;
    logic [7:0]  rx_data;

    logic        pld_valid;
    logic        pld_sof;
    logic        pld_eof;
    logic [7:0]  pld_data;

    logic        status_valid;
    logic        status_fcs_ok;
    logic        status_runt;
    logic        status_abort;
    logic [15:0] frm_len;

    modport master (
        output rx_valid, rx_sof, rx_eof, rx_data,
        input  pld_valid, pld_sof, pld_eof, pld_data,
        input  status_valid, status_fcs_ok, status_runt, status_abort, frm_len
    );

    modport slave (
        input  rx_valid, rx_sof, rx_eof, rx_data,
        output pld_valid, pld_sof, pld_eof, pld_data,
        output status_valid, status_fcs_ok, status_runt, status_abort, frm_len
    );
endinterface

// File: rtl/peg_l2_fcs_chk.sv
// Receive-side FCS checker: strips the trailing 4-byte FCS through a delay line, checks it
// against the CRC-32 of the payload, reports one status record per frame and counts good/bad frames.
module peg_l2_fcs_chk #(
    parameter logic [31:0] CRC_INIT_VAL = 32'hFFFF_FFFF,
    parameter int unsigned MIN_FRM_LEN  = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    peg_l2_fcs_chk_if.slave         s_if,
    input  logic                    i_cnt_clr,
    output logic [31:0]             o_cnt_good,
    output logic [31:0]             o_cnt_bad
);

    localparam logic [15:0] MIN_LEN = 16'(MIN_FRM_LEN);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_PASS
    } state_t;

    // Data bit 0 is the first bit on the wire, matching the transmit-side generator.
    function automatic logic [31:0] nextCRC32_D8(input logic [7:0] data, input logic [31:0] crc);
        logic [31:0] c;
        logic        fb;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            fb = c[31] ^ data[i];
            c  = {c[30:0], 1'b0} ^ (fb ? 32'h04C1_1DB7 : 32'h0000_0000);
        end
        return c;
    endfunction

    state_t      r_state;
    state_t      w_stateNxt;
    logic [31:0] r_crc;
    logic [31:0] w_crcNxt;
    logic [7:0]  r_dl [0:3];
    logic [7:0]  w_dlNxt [0:3];
    logic [2:0]  r_fcnt;
    logic [2:0]  w_fcntNxt;
    logic [15:0] r_len;
    logic [15:0] w_lenNxt;
    logic        r_sofPend;
    logic        w_sofPendNxt;

    logic        r_pldValid, w_pldValidNxt;
    logic        r_pldSof,   w_pldSofNxt;
    logic        r_pldEof,   w_pldEofNxt;
    logic [7:0]  r_pldData,  w_pldDataNxt;
    logic        r_stValid,  w_stValidNxt;
    logic        r_stFcsOk,  w_stFcsOkNxt;
    logic        r_stRunt,   w_stRuntNxt;
    logic        r_stAbort,  w_stAbortNxt;
    logic [15:0] r_frmLen,   w_frmLenNxt;

    logic [31:0] r_cntGood;
    logic [31:0] r_cntBad;

    logic [31:0] w_crcUpd;
    logic [31:0] w_expFcs;
    logic [31:0] w_rxFcs;
    logic [15:0] w_lenInc;

    assign w_crcUpd = nextCRC32_D8(r_dl[3], r_crc);
    assign w_rxFcs  = {s_if.rx_data, r_dl[0], r_dl[1], r_dl[2]};
    assign w_lenInc = (r_len == 16'hFFFF) ? r_len : r_len + 16'd1;

    always_comb begin
        for (int i = 0; i < 32; i++) begin
            w_expFcs[i] = ~w_crcUpd[31 - i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_stateNxt;
        end
    end

    always_comb begin
        w_stateNxt    = r_state;
        w_crcNxt      = r_crc;
        w_dlNxt       = r_dl;
        w_fcntNxt     = r_fcnt;
        w_lenNxt      = r_len;
        w_sofPendNxt  = r_sofPend;
        w_pldValidNxt = 1'b0;
        w_pldSofNxt   = 1'b0;
        w_pldEofNxt   = 1'b0;
        w_pldDataNxt  = r_pldData;
        w_stValidNxt  = 1'b0;
        w_stFcsOkNxt  = r_stFcsOk;
        w_stRuntNxt   = r_stRunt;
        w_stAbortNxt  = r_stAbort;
        w_frmLenNxt   = r_frmLen;

        if (s_if.rx_valid) begin
            if (s_if.rx_sof) begin
                // A sof inside a frame closes the old one as aborted before restarting.
                if (r_state != ST_IDLE) begin
                    w_stValidNxt = 1'b1;
                    w_stAbortNxt = 1'b1;
                    w_stFcsOkNxt = 1'b0;
                    w_stRuntNxt  = (r_len < MIN_LEN);
                    w_frmLenNxt  = r_len;
                end
                w_crcNxt     = CRC_INIT_VAL;
                w_dlNxt[0]   = s_if.rx_data;
                w_fcntNxt    = 3'd1;
                w_lenNxt     = 16'd1;
                w_sofPendNxt = 1'b1;
                if (s_if.rx_eof) begin
                    if (r_state == ST_IDLE) begin
                        w_stValidNxt = 1'b1;
                        w_stAbortNxt = 1'b0;
                        w_stFcsOkNxt = 1'b0;
                        w_stRuntNxt  = 1'b1;
                        w_frmLenNxt  = 16'd1;
                    end
                    w_fcntNxt  = 3'd0;
                    w_stateNxt = ST_IDLE;
                end else begin
                    w_stateNxt = ST_FILL;
                end
            end else begin
                case (r_state)
                    ST_FILL: begin
                        w_dlNxt   = '{s_if.rx_data, r_dl[0], r_dl[1], r_dl[2]};
                        w_fcntNxt = r_fcnt + 3'd1;
                        w_lenNxt  = w_lenInc;
                        if (s_if.rx_eof) begin
                            w_stValidNxt = 1'b1;
                            w_stAbortNxt = 1'b0;
                            w_stFcsOkNxt = 1'b0;
                            w_stRuntNxt  = 1'b1;
                            w_frmLenNxt  = w_lenInc;
                            w_fcntNxt    = 3'd0;
                            w_stateNxt   = ST_IDLE;
                        end else if (r_fcnt == 3'd3) begin
                            w_stateNxt = ST_PASS;
                        end
                    end
                    ST_PASS: begin
                        w_dlNxt       = '{s_if.rx_data, r_dl[0], r_dl[1], r_dl[2]};
                        w_crcNxt      = w_crcUpd;
                        w_lenNxt      = w_lenInc;
                        w_pldValidNxt = 1'b1;
                        w_pldSofNxt   = r_sofPend;
                        w_pldDataNxt  = r_dl[3];
                        w_sofPendNxt  = 1'b0;
                        if (s_if.rx_eof) begin
                            w_pldEofNxt  = 1'b1;
                            w_stValidNxt = 1'b1;
                            w_stAbortNxt = 1'b0;
                            w_stFcsOkNxt = (w_expFcs == w_rxFcs);
                            w_stRuntNxt  = (w_lenInc < MIN_LEN);
                            w_frmLenNxt  = w_lenInc;
                            w_fcntNxt    = 3'd0;
                            w_stateNxt   = ST_IDLE;
                        end
                    end
                    default: begin
                        w_stateNxt = ST_IDLE;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_crc      <= CRC_INIT_VAL;
            r_dl       <= '{default: 8'h00};
            r_fcnt     <= 3'd0;
            r_len      <= 16'd0;
            r_sofPend  <= 1'b0;
            r_pldValid <= 1'b0;
            r_pldSof   <= 1'b0;
            r_pldEof   <= 1'b0;
            r_pldData  <= 8'h00;
            r_stValid  <= 1'b0;
            r_stFcsOk  <= 1'b0;
            r_stRunt   <= 1'b0;
            r_stAbort  <= 1'b0;
            r_frmLen   <= 16'd0;
        end else begin
            r_crc      <= w_crcNxt;
            r_dl       <= w_dlNxt;
            r_fcnt     <= w_fcntNxt;
            r_len      <= w_lenNxt;
            r_sofPend  <= w_sofPendNxt;
            r_pldValid <= w_pldValidNxt;
            r_pldSof   <= w_pldSofNxt;
            r_pldEof   <= w_pldEofNxt;
            r_pldData  <= w_pldDataNxt;
            r_stValid  <= w_stValidNxt;
            r_stFcsOk  <= w_stFcsOkNxt;
            r_stRunt   <= w_stRuntNxt;
            r_stAbort  <= w_stAbortNxt;
            r_frmLen   <= w_frmLenNxt;
        end
    end

    // Counters take the status record in the cycle it is presented, so a clear in that cycle wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cntGood <= 32'd0;
            r_cntBad  <= 32'd0;
        end else if (i_cnt_clr) begin
            r_cntGood <= 32'd0;
            r_cntBad  <= 32'd0;
        end else if (r_stValid) begin
            if (r_stFcsOk && !r_stRunt && !r_stAbort) begin
                r_cntGood <= r_cntGood + 32'd1;
            end else begin
                r_cntBad <= r_cntBad + 32'd1;
            end
        end
    end

    assign s_if.pld_valid     = r_pldValid;
    assign s_if.pld_sof       = r_pldSof;
    assign s_if.pld_eof       = r_pldEof;
    assign s_if.pld_data      = r_pldData;
    assign s_if.status_valid  = r_stValid;
    assign s_if.status_fcs_ok = r_stFcsOk;
    assign s_if.status_runt   = r_stRunt;
    assign s_if.status_abort  = r_stAbort;
    assign s_if.frm_len       = r_frmLen;
    assign o_cnt_good         = r_cntGood;
    assign o_cnt_bad          = r_cntBad;

endmodule

// File: tb/tb_peg_l2_fcs_chk.sv
// Directed bench for peg_l2_fcs_chk: one instance at the default minimum length, one at 13 bytes
// for the short CRC check-string frame.
module tb_peg_l2_fcs_chk;

    typedef logic [7:0] bq_t[$];
    typedef struct { logic sof; logic eof; logic [7:0] data; } pld_t;
    typedef struct { logic fcsOk; logic runt; logic abort; logic [15:0] len; } st_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cntClr = 1'b0;
    logic [31:0] cntGood, cntBad, cntGood13, cntBad13;

    int compared = 0;
    int mismatched = 0;

    pld_t pldQ[$];
    st_t  stQ[$];
    st_t  stQ13[$];

    bq_t f123, pA, fA, fABad, pB, fB, fShort, fOne;

    peg_l2_fcs_chk_if ifA ();
    peg_l2_fcs_chk_if ifB ();

    peg_l2_fcs_chk u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_if       (ifA),
        .i_cnt_clr  (cntClr),
        .o_cnt_good (cntGood),
        .o_cnt_bad  (cntBad)
    );

    peg_l2_fcs_chk #(.MIN_FRM_LEN(13)) u_dut13 (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_if       (ifB),
        .i_cnt_clr  (cntClr),
        .o_cnt_good (cntGood13),
        .o_cnt_bad  (cntBad13)
    );

    always #5 clk = ~clk;

    // Record every payload byte and status pulse, sampled mid-cycle.
    always @(negedge clk) begin
        if (ifA.pld_valid === 1'b1)
            pldQ.push_back('{sof: ifA.pld_sof, eof: ifA.pld_eof, data: ifA.pld_data});
        if (ifA.status_valid === 1'b1)
            stQ.push_back('{fcsOk: ifA.status_fcs_ok, runt: ifA.status_runt,
                            abort: ifA.status_abort, len: ifA.frm_len});
        if (ifB.status_valid === 1'b1)
            stQ13.push_back('{fcsOk: ifB.status_fcs_ok, runt: ifB.status_runt,
                              abort: ifB.status_abort, len: ifB.frm_len});
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic bq_t makeSeq(input int n, input int start, input int step);
        bq_t q;
        for (int i = 0; i < n; i++) q.push_back(8'(start + i * step));
        return q;
    endfunction

    // Reflected (LSB-first) CRC-32 reference, FCS appended low byte first.
    function automatic bq_t withFcs(input bq_t p);
        bq_t         f;
        logic [31:0] c;
        f = p;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < p.size(); i++) begin
            c = c ^ {24'h0, p[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        c = ~c;
        f.push_back(c[7:0]);
        f.push_back(c[15:8]);
        f.push_back(c[23:16]);
        f.push_back(c[31:24]);
        return f;
    endfunction

    task automatic applyStimulus(input logic v, input logic sof, input logic eof, input logic [7:0] d);
        @(negedge clk);
        ifA.rx_valid = v; ifA.rx_sof = sof; ifA.rx_eof = eof; ifA.rx_data = d;
        ifB.rx_valid = v; ifB.rx_sof = sof; ifB.rx_eof = eof; ifB.rx_data = d;
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic sendRange(input bq_t f, input int first, input int last, input bit toggle);
        for (int i = first; i <= last; i++) begin
            if (toggle && i > first) idle(1);
            applyStimulus(1'b1, i == 0, i == f.size() - 1, f[i]);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkPayload(input string tag, input bq_t exp, input int base);
        for (int i = 0; i < exp.size(); i++)
            checkOutput($sformatf("%s_byte%0d", tag, i), 32'(pldQ[base + i].data), 32'(exp[i]));
        checkOutput({tag, "_sof"}, 32'(pldQ[base].sof), 1);
        checkOutput({tag, "_eof"}, 32'(pldQ[base + exp.size() - 1].eof), 1);
    endtask

    task automatic clearAll();
        @(negedge clk);
        cntClr = 1'b1;
        @(negedge clk);
        cntClr = 1'b0;
        pldQ.delete();
        stQ.delete();
        stQ13.delete();
    endtask

    initial begin
        f123 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                 8'h26, 8'h39, 8'hF4, 8'hCB};
        pA = makeSeq(60, 0, 1);
        fA = withFcs(pA);
        fABad = fA;
        fABad[10] = fABad[10] ^ 8'h01;
        pB = makeSeq(60, 8'h03, 7);
        fB = withFcs(pB);
        fShort = '{8'hAA, 8'h55, 8'hC3};
        fOne = '{8'h5A};

        // Reset state
        idle(3);
        checkOutput("rst_pld_valid", 32'(ifA.pld_valid), 0);
        checkOutput("rst_status_valid", 32'(ifA.status_valid), 0);
        checkOutput("rst_frm_len", 32'(ifA.frm_len), 0);
        checkOutput("rst_cnt_good", cntGood, 0);
        checkOutput("rst_cnt_bad", cntBad, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // Check string "123456789": latency of first byte, then status aligned with pld_eof
        $display("[TB] check-string frame");
        sendRange(f123, 0, 4, 1'b0);
        idle(1);
        checkOutput("lat_pld_valid", 32'(ifA.pld_valid), 1);
        checkOutput("lat_pld_sof", 32'(ifA.pld_sof), 1);
        checkOutput("lat_pld_data", 32'(ifA.pld_data), 32'h31);
        idle(1);
        checkOutput("gap_pld_valid", 32'(ifA.pld_valid), 0);
        sendRange(f123, 5, 12, 1'b0);
        idle(1);
        checkOutput("eof_status_valid", 32'(ifB.status_valid), 1);
        checkOutput("eof_pld_eof", 32'(ifB.pld_eof), 1);
        idle(3);
        checkOutput("t1_pld_count", 32'(pldQ.size()), 9);
        checkPayload("t1", f123[0:8], 0);
        checkOutput("t1_st13_count", 32'(stQ13.size()), 1);
        checkOutput("t1_st13_fcs_ok", 32'(stQ13[0].fcsOk), 1);
        checkOutput("t1_st13_runt", 32'(stQ13[0].runt), 0);
        checkOutput("t1_st13_abort", 32'(stQ13[0].abort), 0);
        checkOutput("t1_st13_len", 32'(stQ13[0].len), 13);
        checkOutput("t1_st64_runt", 32'(stQ[0].runt), 1);
        checkOutput("t1_st64_fcs_ok", 32'(stQ[0].fcsOk), 1);
        checkOutput("t1_cnt13_good", cntGood13, 1);
        checkOutput("t1_cnt13_bad", cntBad13, 0);
        checkOutput("t1_cnt64_bad", cntBad, 1);

        // 64-byte good frame then the same frame with one payload bit flipped
        $display("[TB] good and corrupted 64-byte frames");
        clearAll();
        sendRange(fA, 0, 63, 1'b0);
        idle(2);
        sendRange(fABad, 0, 63, 1'b0);
        idle(4);
        checkOutput("t2_st_count", 32'(stQ.size()), 2);
        checkOutput("t2_good_fcs_ok", 32'(stQ[0].fcsOk), 1);
        checkOutput("t2_good_runt", 32'(stQ[0].runt), 0);
        checkOutput("t2_good_len", 32'(stQ[0].len), 64);
        checkOutput("t2_bad_fcs_ok", 32'(stQ[1].fcsOk), 0);
        checkOutput("t2_bad_len", 32'(stQ[1].len), 64);
        checkOutput("t2_pld_count", 32'(pldQ.size()), 120);
        checkPayload("t2a", pA, 0);
        checkOutput("t2_flipped_byte", 32'(pldQ[70].data), 32'h0B);
        checkOutput("t2_cnt_good", cntGood, 1);
        checkOutput("t2_cnt_bad", cntBad, 1);

        // Runt frames: 3 bytes, then a single sof+eof byte
        $display("[TB] runt frames");
        clearAll();
        sendRange(fShort, 0, 2, 1'b0);
        idle(4);
        checkOutput("t3_pld_count", 32'(pldQ.size()), 0);
        checkOutput("t3_st_count", 32'(stQ.size()), 1);
        checkOutput("t3_runt", 32'(stQ[0].runt), 1);
        checkOutput("t3_fcs_ok", 32'(stQ[0].fcsOk), 0);
        checkOutput("t3_abort", 32'(stQ[0].abort), 0);
        checkOutput("t3_len", 32'(stQ[0].len), 3);
        checkOutput("t3_cnt_bad", cntBad, 1);
        sendRange(fOne, 0, 0, 1'b0);
        idle(4);
        checkOutput("t3b_st_count", 32'(stQ.size()), 2);
        checkOutput("t3b_runt", 32'(stQ[1].runt), 1);
        checkOutput("t3b_len", 32'(stQ[1].len), 1);
        checkOutput("t3b_pld_count", 32'(pldQ.size()), 0);
        checkOutput("t3b_cnt_bad", cntBad, 2);
        checkOutput("t3b_cnt_good", cntGood, 0);

        // Gapped frame followed back-to-back by the same frame at full rate
        $display("[TB] gapped and back-to-back frames");
        clearAll();
        sendRange(fB, 0, 63, 1'b1);
        sendRange(fB, 0, 63, 1'b0);
        idle(4);
        checkOutput("t4_st_count", 32'(stQ.size()), 2);
        checkOutput("t4_a_fcs_ok", 32'(stQ[0].fcsOk), 1);
        checkOutput("t4_a_len", 32'(stQ[0].len), 64);
        checkOutput("t4_b_fcs_ok", 32'(stQ[1].fcsOk), 1);
        checkOutput("t4_b_len", 32'(stQ[1].len), 64);
        checkOutput("t4_pld_count", 32'(pldQ.size()), 120);
        checkPayload("t4a", pB, 0);
        checkPayload("t4b", pB, 60);
        checkOutput("t4_cnt_good", cntGood, 2);
        checkOutput("t4_cnt_bad", cntBad, 0);

        // Abort by sof at byte 20, new frame checks normally
        $display("[TB] abort by early sof");
        clearAll();
        sendRange(fA, 0, 18, 1'b0);
        sendRange(fB, 0, 63, 1'b0);
        idle(4);
        checkOutput("t5_st_count", 32'(stQ.size()), 2);
        checkOutput("t5_abort", 32'(stQ[0].abort), 1);
        checkOutput("t5_abort_fcs_ok", 32'(stQ[0].fcsOk), 0);
        checkOutput("t5_abort_len", 32'(stQ[0].len), 19);
        checkOutput("t5_new_abort", 32'(stQ[1].abort), 0);
        checkOutput("t5_new_fcs_ok", 32'(stQ[1].fcsOk), 1);
        checkOutput("t5_new_len", 32'(stQ[1].len), 64);
        checkOutput("t5_pld_count", 32'(pldQ.size()), 75);
        checkOutput("t5_old_no_eof", 32'(pldQ[14].eof), 0);
        checkOutput("t5_old_sof", 32'(pldQ[0].sof), 1);
        checkPayload("t5b", pB, 15);
        checkOutput("t5_cnt_good", cntGood, 1);
        checkOutput("t5_cnt_bad", cntBad, 1);

        // Counter clear coincident with a status pulse
        sendRange(fB, 0, 63, 1'b0);
        idle(1);
        cntClr = 1'b1;
        checkOutput("clr_status_pulse", 32'(ifA.status_valid), 1);
        @(negedge clk);
        cntClr = 1'b0;
        idle(2);
        checkOutput("clr_cnt_good", cntGood, 0);
        checkOutput("clr_cnt_bad", cntBad, 0);

        // Reset mid-frame, then a good frame
        $display("[TB] reset mid-frame");
        clearAll();
        sendRange(fB, 0, 63, 1'b0);
        idle(3);
        checkOutput("t6_pre_cnt_good", cntGood, 1);
        stQ.delete();
        sendRange(fB, 0, 28, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, fB[29]);
        rst_n = 1'b0;
        idle(1);
        checkOutput("t6_rst_pld_valid", 32'(ifA.pld_valid), 0);
        checkOutput("t6_rst_frm_len", 32'(ifA.frm_len), 0);
        checkOutput("t6_rst_cnt_good", cntGood, 0);
        idle(1);
        rst_n = 1'b1;
        idle(2);
        pldQ.delete();
        sendRange(fB, 0, 63, 1'b0);
        idle(4);
        checkOutput("t6_st_count", 32'(stQ.size()), 1);
        checkOutput("t6_fcs_ok", 32'(stQ[0].fcsOk), 1);
        checkOutput("t6_len", 32'(stQ[0].len), 64);
        checkOutput("t6_pld_count", 32'(pldQ.size()), 60);
        checkPayload("t6", pB, 0);
        checkOutput("t6_cnt_good", cntGood, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
